// File: rtl/button_event_gen_pkg.sv
// Shared constants, encodings and helpers for the button event generator.
package button_event_pkg;

  // Button bit positions inside btn_raw / btn_db.
  localparam int unsigned BTN_L   = 0;
  localparam int unsigned BTN_R   = 1;
  localparam int unsigned BTN_U   = 2;
  localparam int unsigned BTN_D   = 3;
  localparam int unsigned BTN_C   = 4;
  localparam int unsigned NUM_BTN = 5;

  // Cursor move direction as presented on move_dir.
  typedef enum logic [1:0] {
    DIR_L = 2'b00,
    DIR_R = 2'b01,
    DIR_U = 2'b10,
    DIR_D = 2'b11
  } dir_e;

  // Move strobe FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_ACCEL = 2'b10
  } move_state_e;

  // Increment a 6-bit speed value, holding at the given ceiling.
  function automatic logic [5:0] sat_inc(input logic [5:0] v, input logic [5:0] lim);
    return (v >= lim) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/button_event_gen_if.sv
// Button input / cursor event bundle between pins, generator and cursor logic.
interface button_event_gen_if;
  logic       sample_tick;
  logic       cursor_en;
  logic [4:0] btn_raw;
  logic [4:0] btn_db;
  logic       c_pulse;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [6:0] move_step;

  // Event generator side.
  modport master (
    input  sample_tick, cursor_en, btn_raw,
    output btn_db, c_pulse, move_valid, move_dir, move_step
  );

  // Stimulus / consumer side.
  modport slave (
    output sample_tick, cursor_en, btn_raw,
    input  btn_db, c_pulse, move_valid, move_dir, move_step
  );
endinterface

// File: rtl/button_event_gen_debounce.sv
// Single-bit 2-flop synchroniser followed by a tick-paced debouncer.
module button_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic raw,
  output logic db
);

  // Counter only ever holds 0..DEBOUNCE_TICKS-1; the flip happens instead of the last increment.
  localparam int unsigned CW = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          db_r;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive differing ticks; flip the level when the run is long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      db_r  <= 1'b0;
    end else if (sample_tick) begin
      if (sync2_r == db_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_r <= {CW{1'b0}};
        db_r  <= ~db_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign db = db_r;

endmodule

// File: rtl/button_event_gen.sv
// Debounces the five buttons and produces centre-click and accelerating cursor-move events.
module button_event_gen #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY   = 3,
  parameter int unsigned MAX_SPEED      = 63
) (
  input  logic                clk,
  input  logic                rst_n,
  button_event_gen_if.master  bus
);
  import button_event_pkg::*;

  // Hold counter must reach REPEAT_DELAY; keep at least 2 bits.
  localparam int unsigned    HW        = ($clog2(REPEAT_DELAY + 1) < 2) ? 2 : $clog2(REPEAT_DELAY + 1);
  localparam logic [HW-1:0]  H_LAST    = HW'(REPEAT_DELAY);
  localparam logic [5:0]     SPEED_MAX = 6'(MAX_SPEED);

  logic [NUM_BTN-1:0] db_s;
  logic               c_prev_r;
  logic               c_pulse_r;
  logic               c_rise_s;
  logic [3:0]         dir_bits_s;
  logic               single_dir_s;
  logic               same_dir_s;
  dir_e               dir_now_s;

  move_state_e        state_r, state_nxt;
  logic [HW-1:0]      h_r, h_nxt;
  logic [5:0]         speed_r, speed_nxt;
  dir_e               dir_r, dir_nxt;
  logic               strobe_s;
  logic [6:0]         step_s;
  logic               move_valid_r;
  dir_e               move_dir_r;
  logic [6:0]         move_step_r;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_tick (bus.sample_tick),
      .raw         (bus.btn_raw[gi]),
      .db          (db_s[gi])
    );
  end

  assign c_rise_s = db_s[BTN_C] & ~c_prev_r;

  // Centre click: one pulse per rise, only in cursor mode with no direction held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_prev_r  <= 1'b0;
      c_pulse_r <= 1'b0;
    end else begin
      c_prev_r  <= db_s[BTN_C];
      c_pulse_r <= c_rise_s & bus.cursor_en & ~(|dir_bits_s);
    end
  end

  // Decode which single direction (if any) is currently requested.
  always_comb begin
    dir_bits_s   = {db_s[BTN_D], db_s[BTN_U], db_s[BTN_R], db_s[BTN_L]};
    dir_now_s    = DIR_L;
    single_dir_s = 1'b0;
    case (dir_bits_s)
      4'b0001: begin dir_now_s = DIR_L; single_dir_s = 1'b1; end
      4'b0010: begin dir_now_s = DIR_R; single_dir_s = 1'b1; end
      4'b0100: begin dir_now_s = DIR_U; single_dir_s = 1'b1; end
      4'b1000: begin dir_now_s = DIR_D; single_dir_s = 1'b1; end
      default: begin dir_now_s = DIR_L; single_dir_s = 1'b0; end
    endcase
    single_dir_s = single_dir_s & bus.cursor_en & ~db_s[BTN_C];
    same_dir_s   = single_dir_s & (dir_now_s == dir_r);
  end

  // FSM state, hold count, speed and latched direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      h_r     <= {HW{1'b0}};
      speed_r <= 6'd0;
      dir_r   <= DIR_L;
    end else begin
      state_r <= state_nxt;
      h_r     <= h_nxt;
      speed_r <= speed_nxt;
      dir_r   <= dir_nxt;
    end
  end

  // Next state; entering ACCEL already bumps speed so the first accelerated step is 2.
  always_comb begin
    state_nxt = state_r;
    h_nxt     = h_r;
    speed_nxt = speed_r;
    dir_nxt   = dir_r;
    if (bus.sample_tick) begin
      case (state_r)
        ST_IDLE: begin
          if (single_dir_s) begin
            dir_nxt = dir_now_s;
            h_nxt   = HW'(1);
            if (REPEAT_DELAY == 32'd1) begin
              state_nxt = ST_ACCEL;
              speed_nxt = sat_inc(6'd0, SPEED_MAX);
            end else begin
              state_nxt = ST_HOLD;
              speed_nxt = 6'd0;
            end
          end else begin
            state_nxt = ST_IDLE;
            h_nxt     = {HW{1'b0}};
            speed_nxt = 6'd0;
          end
        end
        ST_HOLD: begin
          if (same_dir_s) begin
            h_nxt = h_r + HW'(1);
            if ((h_r + HW'(1)) == H_LAST) begin
              state_nxt = ST_ACCEL;
              speed_nxt = sat_inc(speed_r, SPEED_MAX);
            end else begin
              state_nxt = ST_HOLD;
            end
          end else begin
            state_nxt = ST_IDLE;
            h_nxt     = {HW{1'b0}};
            speed_nxt = 6'd0;
          end
        end
        ST_ACCEL: begin
          if (same_dir_s) begin
            speed_nxt = sat_inc(speed_r, SPEED_MAX);
          end else begin
            state_nxt = ST_IDLE;
            h_nxt     = {HW{1'b0}};
            speed_nxt = 6'd0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          h_nxt     = {HW{1'b0}};
          speed_nxt = 6'd0;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // Strobe and step size for the current tick; aborts never strobe.
  always_comb begin
    strobe_s = 1'b0;
    step_s   = 7'd1;
    if (bus.sample_tick) begin
      case (state_r)
        ST_IDLE:  strobe_s = single_dir_s;
        ST_HOLD:  strobe_s = same_dir_s;
        ST_ACCEL: begin
          strobe_s = same_dir_s;
          step_s   = {1'b0, speed_r} + 7'd1;
        end
        default:  strobe_s = 1'b0;
      endcase
    end else begin
      strobe_s = 1'b0;
    end
  end

  // Registered move outputs; direction and step hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_valid_r <= 1'b0;
      move_dir_r   <= DIR_L;
      move_step_r  <= 7'd1;
    end else begin
      move_valid_r <= strobe_s;
      if (strobe_s) begin
        move_dir_r  <= dir_now_s;
        move_step_r <= step_s;
      end
    end
  end

  assign bus.btn_db     = db_s;
  assign bus.c_pulse    = c_pulse_r;
  assign bus.move_valid = move_valid_r;
  assign bus.move_dir   = move_dir_r;
  assign bus.move_step  = move_step_r;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: debounce, click, acceleration, abort and reset.
module tb_button_event_gen;

  localparam logic [4:0] B_L = 5'b00001;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_U = 5'b00100;
  localparam logic [4:0] B_D = 5'b01000;
  localparam logic [4:0] B_C = 5'b10000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   nvalid;
  int   npulse;
  int unsigned accel_exp [8] = '{1, 1, 1, 2, 3, 4, 5, 6};

  button_event_gen_if bus ();

  button_event_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One sample_tick cycle; outputs it produced are visible on return.
  task automatic tick();
    bus.sample_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.sample_tick = 1'b0;
    nvalid += 32'(bus.move_valid);
    npulse += 32'(bus.c_pulse);
  endtask

  // Change the raw buttons and let the synchroniser settle.
  task automatic set_raw(input logic [4:0] v);
    bus.btn_raw = v;
    idle();
    idle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nvalid = 0;
    npulse = 0;
    bus.sample_tick = 1'b0;
    bus.cursor_en   = 1'b0;
    bus.btn_raw     = 5'b00000;
    rst_n = 1'b0;
    idle(); idle(); idle();
    check("rst_db",    32'(bus.btn_db), 32'd0);
    check("rst_cp",    32'(bus.c_pulse), 32'd0);
    check("rst_valid", 32'(bus.move_valid), 32'd0);
    check("rst_dir",   32'(bus.move_dir), 32'd0);
    check("rst_step",  32'(bus.move_step), 32'd1);
    rst_n = 1'b1;
    idle();

    // Bouncing R never reaches the debounce threshold.
    bus.cursor_en = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) set_raw((i % 4 == 0) ? B_R : 5'b00000);
      tick();
      check("bounce_db", 32'(bus.btn_db[1]), 32'd0);
    end
    set_raw(B_R);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("steady_db", 32'(bus.btn_db[1]), (k == 4) ? 32'd1 : 32'd0);
    end
    check("bounce_nomove", 32'(nvalid), 32'd0);

    // Acceleration on R.
    for (int k = 0; k < 8; k++) begin
      tick();
      check("acc_valid", 32'(bus.move_valid), 32'd1);
      check("acc_dir",   32'(bus.move_dir), 32'd1);
      check("acc_step",  32'(bus.move_step), 32'(accel_exp[k]));
    end
    idle();
    check("pulse_width", 32'(bus.move_valid), 32'd0);

    // Dropping cursor_en mid-hold aborts with no strobe; step is held.
    bus.cursor_en = 1'b0;
    tick();
    check("en_abort", 32'(bus.move_valid), 32'd0);
    nvalid = 0;
    ticks(3);
    check("en_off_nomove", 32'(nvalid), 32'd0);
    check("step_held", 32'(bus.move_step), 32'd6);

    // L+R together never moves.
    set_raw(B_L | B_R);
    ticks(4);
    check("lr_db", 32'(bus.btn_db), 32'(B_L | B_R));
    bus.cursor_en = 1'b1;
    nvalid = 0;
    ticks(6);
    check("lr_nomove", 32'(nvalid), 32'd0);
    set_raw(5'b00000);
    ticks(6);
    check("release_db", 32'(bus.btn_db), 32'd0);

    // Centre click: single pulse over a long hold.
    set_raw(B_C);
    ticks(4);
    check("c_db", 32'(bus.btn_db[4]), 32'd1);
    check("c_pre", 32'(bus.c_pulse), 32'd0);
    npulse = 0;
    nvalid = 0;
    tick();
    check("c_lat", 32'(bus.c_pulse), 32'd1);
    ticks(45);
    check("c_count", 32'(npulse), 32'd1);
    check("c_nomove", 32'(nvalid), 32'd0);
    set_raw(5'b00000);
    ticks(6);

    // C pressed while D held: no click, movement stops.
    set_raw(B_D);
    ticks(4);
    tick();
    check("d_dir", 32'(bus.move_dir), 32'd3);
    tick();
    set_raw(B_D | B_C);
    npulse = 0;
    ticks(4);
    nvalid = 0;
    ticks(6);
    check("dc_nopulse", 32'(npulse), 32'd0);
    check("dc_nomove", 32'(nvalid), 32'd0);
    set_raw(5'b00000);
    ticks(6);

    // Hold U long enough to saturate.
    set_raw(B_U);
    ticks(4);
    for (int k = 1; k <= 80; k++) begin
      tick();
      check("sat_valid", 32'(bus.move_valid), 32'd1);
      check("sat_step", 32'(bus.move_step), (k <= 3) ? 32'd1 : ((k - 2 > 64) ? 32'd64 : 32'(k - 2)));
    end
    check("sat_dir", 32'(bus.move_dir), 32'd2);

    // Switch U -> L: one silent tick, then a fresh L move.
    set_raw(B_L);
    ticks(4);
    check("sw_pre_dir",  32'(bus.move_dir), 32'd2);
    check("sw_pre_step", 32'(bus.move_step), 32'd64);
    tick();
    check("sw_abort", 32'(bus.move_valid), 32'd0);
    tick();
    check("l_valid", 32'(bus.move_valid), 32'd1);
    check("l_dir",   32'(bus.move_dir), 32'd0);
    check("l_step",  32'(bus.move_step), 32'd1);
    ticks(11);
    check("pre_rst_step", 32'(bus.move_step), 32'd10);

    // Asynchronous reset mid-hold.
    rst_n = 1'b0;
    #1;
    check("mrst_db",    32'(bus.btn_db), 32'd0);
    check("mrst_valid", 32'(bus.move_valid), 32'd0);
    check("mrst_step",  32'(bus.move_step), 32'd1);
    check("mrst_dir",   32'(bus.move_dir), 32'd0);
    idle();
    rst_n = 1'b1;
    check("post_rst_step", 32'(bus.move_step), 32'd1);
    idle();
    idle();
    nvalid = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rdb_db", 32'(bus.btn_db[0]), (k == 4) ? 32'd1 : 32'd0);
    end
    check("rdb_nomove", 32'(nvalid), 32'd0);
    tick();
    check("rdb_valid", 32'(bus.move_valid), 32'd1);
    check("rdb_step",  32'(bus.move_step), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_gen.md
# button_event_gen

Conditions the five raw push-buttons (L, R, U, D, C) into the clean event stream consumed by the cursor/menu logic. It synchronises and debounces each button, emits a single-cycle centre-click pulse, and emits rate-limited cursor-move strobes whose step size accelerates while one direction is held. It sits between the board button pins and the cursor drawing block, replacing ad-hoc edge detection and speed ramps there.

## Interface
Parameters:
- DEBOUNCE_TICKS, 4: consecutive sample ticks a synchronised input must differ from its debounced value before the debounced value flips (≥1).
- REPEAT_DELAY, 3: move strobes at step 1 before acceleration starts (≥1).
- MAX_SPEED, 63: saturation value of the speed counter (≤63).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle strobe from the clock divider; paces debounce and move rate.
- cursor_en  in  1  cursor mode enable (cursor switch).
- btn_raw  in  5  raw asynchronous buttons, index 0..4 = L, R, U, D, C.
- btn_db  out  5  debounced button levels, same indexing.
- c_pulse  out  1  one-cycle centre-click event.
- move_valid  out  1  one-cycle cursor-move strobe.
- move_dir  out  2  direction of move: 00 L, 01 R, 10 U, 11 D; held from last strobe.
- move_step  out  7  pixels to move, 1..MAX_SPEED+1; held from last strobe.

## Operation
- Sync: each btn_raw bit passes a 2-flop synchroniser every clk.
- Debounce, per bit: counter clears on any sample_tick where sync equals btn_db. It increments on a sample_tick where they differ. On the tick that would reach DEBOUNCE_TICKS, btn_db flips and the counter clears. No update between ticks.
- c_pulse: asserted one cycle after btn_db[C] rises, only if cursor_en = 1 and btn_db[L,R,U,D] are all 0 in the rise cycle. Holding C produces no further pulses.
- single_dir: cursor_en & btn_db[C] = 0 & exactly one of btn_db[L,R,U,D] set; dir_now is its encoding.
- Move FSM, states IDLE, HOLD, ACCEL. Registers: hold count h (2+ bits) and speed (6 bits).
  - IDLE: a sample_tick with single_dir emits a strobe with step 1 and dir_now. Sets h = 1, latches the direction. Goes to ACCEL if REPEAT_DELAY = 1, else to HOLD.
  - HOLD: each sample_tick with single_dir and an unchanged direction emits step 1 and increments h. On reaching REPEAT_DELAY it goes to ACCEL.
  - ACCEL: each sample_tick emits step = speed+1, then speed = min(speed+1, MAX_SPEED).
  - Abort: in any state, single_dir false or a direction change moves the FSM to IDLE and clears h and speed, with no strobe that cycle. A new direction starts fresh on the next tick.
- Arithmetic: move_step = {1'b0, speed} + 1, unsigned, 7 bits; no wrap possible.

## Timing
- Reset (async assert, sync-safe release): btn_db = 0, sync flops = 0, debounce counters = 0, c_pulse = 0, move_valid = 0, move_dir = 00, move_step = 1, FSM = IDLE, h = 0, speed = 0.
- Raw to btn_db: 2 clk sync, then DEBOUNCE_TICKS sample_ticks, flip registered on the last tick.
- move_valid, move_dir and move_step are registered and appear the cycle after the qualifying sample_tick. c_pulse likewise appears the cycle after the btn_db rise. All are pulses of exactly one clk.
- Continuous sample_tick (every cycle) must work: one strobe per cycle while held.
- A sample_tick in the same cycle that btn_db changes uses the pre-change btn_db.
- cursor_en falling mid-hold aborts on the next sample_tick, with no strobe.
- Reset mid-operation clears everything immediately. The first post-reset strobe needs a full debounce.

## Structure
- Package button_event_pkg holds:
  - button index constants BTN_L = 0, BTN_R = 1, BTN_U = 2, BTN_D = 3, BTN_C = 4;
  - direction encodings DIR_L, DIR_R, DIR_U, DIR_D;
  - the FSM state enum.
- Sub-module button_debounce: 2-flop sync, counter and debounced output for one bit, parameterised by DEBOUNCE_TICKS. It is instantiated 5 times.

## Test plan
- Reset: assert rst_n = 0 mid-hold with speed = 10. Response: all outputs take their reset values in the same cycle; move_step = 1 after release.
- Bounce: toggle btn_raw[R] every 2 ticks for 20 ticks, then hold steady for 4 ticks. Response: btn_db[R] stays 0 until exactly the 4th steady tick, and no move_valid occurs before that.
- Click: press C for 50 ticks with cursor_en = 1. Response: exactly one c_pulse. Pressing C while D is held produces no c_pulse and no move.
- Acceleration: hold R with defaults for 8 ticks. Response: 8 strobes, dir = 01, steps 1,1,1,2,3,4,5,6.
- Saturation and abort: hold U for 80 ticks, then switch to L. Response: step saturates at 64. The first L tick gives no strobe; the next gives dir = 00, step 1.
- Multi-press and enable: hold L+R, or hold R with cursor_en = 0. Response: no move_valid.
